stage_pingpong: RTL and testbench

Double-buffered inter-stage memory for the pipelined FFT. It replaces the single-bank stage RAM so that stage k can write frame f+1 while stage k+1 reads frame f. It holds two banks of N words, each written and read as butterfly pairs (two addresses per cycle). It tracks frame completion by counting pairs, and handshakes bank ownership between the write and read sides. Sticky error flags report protocol violations.

---
 rtl/stage_pingpong_pkg.sv | 14 +
 rtl/stage_bank.sv | 42 ++++
 rtl/stage_pingpong.sv | 108 ++++++++++
 tb/tb_stage_pingpong.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/stage_pingpong_pkg.sv
// Shared constants for the pipelined FFT stage memories: error bit positions
// and the frame-size consistency check used at elaboration.
package stage_pingpong_pkg;

    localparam int ERR_W         = 3;
    localparam int ERR_OVERFLOW  = 0;
    localparam int ERR_UNDERFLOW = 1;
    localparam int ERR_COLLISION = 2;

    function automatic bit log2_consistent(input int n, input int log_n);
        return (n >= 4) && (n == (1 << log_n));
    endfunction

endpackage

// File: rtl/stage_bank.sv
// One N x WIDTH frame bank: two write ports (port 1 wins on equal addresses)
// and two registered read ports that hold their value when not read.
module stage_bank #(
    parameter int N     = 8,
    parameter int LOG_N = 3,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [LOG_N-1:0] waddr0,
    input  logic [LOG_N-1:0] waddr1,
    input  logic [WIDTH-1:0] wdata0,
    input  logic [WIDTH-1:0] wdata1,
    input  logic             re,
    input  logic [LOG_N-1:0] raddr0,
    input  logic [LOG_N-1:0] raddr1,
    output logic [WIDTH-1:0] rdata0,
    output logic [WIDTH-1:0] rdata1
);

    logic [WIDTH-1:0] mem [N];

    // NOTE: the memory array has no reset so it maps onto RAM; only the read registers are reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr0] <= wdata0;
            mem[waddr1] <= wdata1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata0 <= '0;
            rdata1 <= '0;
        end else if (re) begin
            rdata0 <= mem[raddr0];
            rdata1 <= mem[raddr1];
        end
    end

endmodule

// File: rtl/stage_pingpong.sv
// Double-buffered FFT inter-stage memory: the write side fills one bank while
// the read side drains the other, with ownership tracked by per-bank full flags.
module stage_pingpong
    import stage_pingpong_pkg::*;
#(
    parameter int N     = 8,
    parameter int LOG_N = 3,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_nd,
    input  logic [LOG_N-1:0] in_addr0,
    input  logic [LOG_N-1:0] in_addr1,
    input  logic [WIDTH-1:0] in_data0,
    input  logic [WIDTH-1:0] in_data1,
    output logic             in_ready,
    input  logic             out_rd,
    input  logic [LOG_N-1:0] out_addr0,
    input  logic [LOG_N-1:0] out_addr1,
    output logic             out_nd,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic             out_avail,
    output logic [ERR_W-1:0] err_flags,
    output logic             error
);

    localparam int             CNT_W     = LOG_N - 1;
    localparam logic [CNT_W-1:0] LAST_PAIR = CNT_W'(N / 2 - 1);

    if (!log2_consistent(N, LOG_N)) begin : g_bad_params
        $error("stage_pingpong: N must equal 2**LOG_N and be at least 4");
    end

    logic             wbank, rbank, rsel;
    logic [1:0]       full, full_n;
    logic [CNT_W-1:0] wcount, rcount;
    logic             wr_acc, rd_acc, wr_last, rd_last;
    logic [WIDTH-1:0] bank_rdata0 [2];
    logic [WIDTH-1:0] bank_rdata1 [2];

    assign in_ready  = ~full[wbank];
    assign out_avail = full[rbank];
    assign wr_acc    = in_nd & in_ready;
    assign rd_acc    = out_rd & out_avail;
    assign wr_last   = wr_acc && (wcount == LAST_PAIR);
    assign rd_last   = rd_acc && (rcount == LAST_PAIR);

    // NOTE: blocking assignments in always_comb, defaulted first so no latch is inferred.
    always_comb begin
        full_n = full;
        if (wr_last) full_n[wbank] = 1'b1;
        if (rd_last) full_n[rbank] = 1'b0;
    end

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wbank     <= 1'b0;
            rbank     <= 1'b0;
            rsel      <= 1'b0;
            full      <= '0;
            wcount    <= '0;
            rcount    <= '0;
            out_nd    <= 1'b0;
            err_flags <= '0;
        end else begin
            full   <= full_n;
            out_nd <= rd_acc;
            if (wr_acc) begin
                wcount <= wr_last ? '0 : wcount + 1'b1;
                if (wr_last) wbank <= ~wbank;
            end
            if (rd_acc) begin
                rsel   <= rbank;
                rcount <= rd_last ? '0 : rcount + 1'b1;
                if (rd_last) rbank <= ~rbank;
            end
            if (in_nd && !in_ready)                err_flags[ERR_OVERFLOW]  <= 1'b1;
            if (out_rd && !out_avail)              err_flags[ERR_UNDERFLOW] <= 1'b1;
            if (wr_acc && (in_addr0 == in_addr1))  err_flags[ERR_COLLISION] <= 1'b1;
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_bank
        stage_bank #(.N(N), .LOG_N(LOG_N), .WIDTH(WIDTH)) u_bank (
            .clk    (clk),
            .rst_n  (rst_n),
            .we     (wr_acc && (wbank == 1'(i))),
            .waddr0 (in_addr0),
            .waddr1 (in_addr1),
            .wdata0 (in_data0),
            .wdata1 (in_data1),
            .re     (rd_acc && (rbank == 1'(i))),
            .raddr0 (out_addr0),
            .raddr1 (out_addr1),
            .rdata0 (bank_rdata0[i]),
            .rdata1 (bank_rdata1[i])
        );
    end

    // The last-read bank stays selected, so out_data holds between reads.
    assign out_data0 = bank_rdata0[rsel];
    assign out_data1 = bank_rdata1[rsel];
    assign error     = |err_flags;

endmodule

// File: tb/tb_stage_pingpong.sv
// Directed self-checking bench for stage_pingpong (N=8, WIDTH=32).
module tb_stage_pingpong;

    localparam int N     = 8;
    localparam int LOG_N = 3;
    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_nd = 1'b0;
    logic [LOG_N-1:0] in_addr0 = '0, in_addr1 = '0;
    logic [WIDTH-1:0] in_data0 = '0, in_data1 = '0;
    logic             in_ready;
    logic             out_rd = 1'b0;
    logic [LOG_N-1:0] out_addr0 = '0, out_addr1 = '0;
    logic             out_nd;
    logic [WIDTH-1:0] out_data0, out_data1;
    logic             out_avail;
    logic [2:0]       err_flags;
    logic             error;

    int n_asserts = 0;
    int n_fail    = 0;

    int pa0 [4] = '{0, 1, 2, 3};
    int pa1 [4] = '{4, 5, 6, 7};

    stage_pingpong #(.N(N), .LOG_N(LOG_N), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_nd     (in_nd),
        .in_addr0  (in_addr0),
        .in_addr1  (in_addr1),
        .in_data0  (in_data0),
        .in_data1  (in_data1),
        .in_ready  (in_ready),
        .out_rd    (out_rd),
        .out_addr0 (out_addr0),
        .out_addr1 (out_addr1),
        .out_nd    (out_nd),
        .out_data0 (out_data0),
        .out_data1 (out_data1),
        .out_avail (out_avail),
        .err_flags (err_flags),
        .error     (error)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic write_pair(input int a0, input int a1, input int d0, input int d1);
        in_nd    = 1'b1;
        in_addr0 = LOG_N'(a0);
        in_addr1 = LOG_N'(a1);
        in_data0 = WIDTH'(d0);
        in_data1 = WIDTH'(d1);
        tick();
        in_nd = 1'b0;
    endtask

    task automatic read_pair(input string tag, input int a0, input int a1, input int e0, input int e1);
        out_rd    = 1'b1;
        out_addr0 = LOG_N'(a0);
        out_addr1 = LOG_N'(a1);
        tick();
        out_rd = 1'b0;
        check({tag, "_nd"}, 64'(out_nd), 64'd1);
        check({tag, "_d0"}, 64'(out_data0), 64'(e0));
        check({tag, "_d1"}, 64'(out_data1), 64'(e1));
    endtask

    // chk_avail: out_avail must stay low until the fourth pair lands.
    task automatic write_frame(input string tag, input int base, input bit chk_avail);
        for (int p = 0; p < 4; p++) begin
            write_pair(pa0[p], pa1[p], base + pa0[p], base + pa1[p]);
            if (chk_avail) check({tag, "_avail"}, 64'(out_avail), 64'(p == 3));
        end
    endtask

    task automatic read_frame(input string tag, input int base);
        for (int p = 3; p >= 0; p--)
            read_pair(tag, pa0[p], pa1[p], base + pa0[p], base + pa1[p]);
    endtask

    initial begin
        // Reset state
        tick();
        pulse_reset();
        check("rst_ready", 64'(in_ready), 64'd1);
        check("rst_avail", 64'(out_avail), 64'd0);
        check("rst_nd", 64'(out_nd), 64'd0);
        check("rst_err", 64'(err_flags), 64'd0);
        check("rst_data0", 64'(out_data0), 64'd0);

        // Single frame, in-order read of the same pairs
        write_frame("t1w", 100, 1'b1);
        for (int p = 0; p < 4; p++)
            read_pair("t1r", pa0[p], pa1[p], 100 + pa0[p], 100 + pa1[p]);
        check("t1_avail_after", 64'(out_avail), 64'd0);
        check("t1_error", 64'(error), 64'd0);
        tick();
        check("t1_idle_nd", 64'(out_nd), 64'd0);

        // Underflow: no frame present, data holds the last pair read (3,7)
        out_rd    = 1'b1;
        out_addr0 = 3'd1;
        out_addr1 = 3'd2;
        tick();
        out_rd = 1'b0;
        check("uf_nd", 64'(out_nd), 64'd0);
        check("uf_err", 64'(err_flags), 64'b010);
        check("uf_d0", 64'(out_data0), 64'd103);
        check("uf_d1", 64'(out_data1), 64'd107);

        // Streaming: write frame f while reading frame f-1, three frames
        pulse_reset();
        write_frame("s0w", 200, 1'b0);
        for (int f = 1; f < 3; f++) begin
            for (int p = 0; p < 4; p++) begin
                check("s_ready", 64'(in_ready), 64'd1);
                out_rd    = 1'b1;
                out_addr0 = LOG_N'(pa0[3-p]);
                out_addr1 = LOG_N'(pa1[3-p]);
                write_pair(pa0[p], pa1[p], 200 + 16*f + pa0[p], 200 + 16*f + pa1[p]);
                out_rd = 1'b0;
                check("s_nd", 64'(out_nd), 64'd1);
                check("s_d0", 64'(out_data0), 64'(200 + 16*(f-1) + pa0[3-p]));
                check("s_d1", 64'(out_data1), 64'(200 + 16*(f-1) + pa1[3-p]));
            end
        end
        read_frame("s2r", 232);
        check("s_avail_end", 64'(out_avail), 64'd0);
        check("s_err", 64'(err_flags), 64'd0);

        // Both banks full, overflow attempt, then drain
        write_frame("f0w", 300, 1'b0);
        check("f_ready_mid", 64'(in_ready), 64'd1);
        write_frame("f1w", 400, 1'b0);
        check("f_ready_full", 64'(in_ready), 64'd0);
        write_pair(0, 4, 32'hDEAD, 32'hBEEF);
        check("f_ovf_err", 64'(err_flags), 64'b001);
        read_frame("f0r", 300);
        check("f_ready_free", 64'(in_ready), 64'd1);
        read_frame("f1r", 400);
        check("f_avail_end", 64'(out_avail), 64'd0);

        // Write collision: addr 2 keeps word 1; re-read of addr 6 counts
        pulse_reset();
        write_pair(2, 2, 32'hAAAA, 32'h5555);
        check("c_err", 64'(err_flags), 64'b100);
        write_pair(0, 4, 600, 604);
        write_pair(1, 5, 601, 605);
        write_pair(3, 6, 603, 606);
        read_pair("c_r0", 2, 0, 32'h5555, 600);
        read_pair("c_r1", 4, 1, 604, 601);
        read_pair("c_r2", 5, 3, 605, 603);
        check("c_avail_mid", 64'(out_avail), 64'd1);
        read_pair("c_r3", 6, 6, 606, 606);
        check("c_avail_end", 64'(out_avail), 64'd0);
        check("c_err_sticky", 64'(err_flags[2]), 64'd1);

        // Reset mid-frame discards the partial frame
        pulse_reset();
        write_pair(0, 4, 700, 704);
        write_pair(1, 5, 701, 705);
        pulse_reset();
        check("r_avail", 64'(out_avail), 64'd0);
        check("r_ready", 64'(in_ready), 64'd1);
        check("r_err", 64'(err_flags), 64'd0);
        check("r_nd", 64'(out_nd), 64'd0);
        write_frame("r_w", 710, 1'b1);
        read_frame("r_r", 710);
        check("r_err_end", 64'(err_flags), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
